fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Consumer end of the branch-resolution interface. Takes the resolved PcSel/BrPC redirect from EX, owns the architectural PC register and sequences instruction fetch.
- Generates same-cycle pipeline flushes and enforces a post-redirect squash window.
- Keeps a redirect performance counter.
- Sits between the EX-stage branch logic, the hazard unit and instruction memory.

Parameters:
- PC_W, 9, width of the PC and instruction-memory byte address.
- RESET_PC, 0, PC value loaded by reset (PC_W bits, word aligned).
- SQUASH_CYCLES, 2, cycles after an accepted redirect during which PcSel is ignored (1..7).
- TRAP_PC, 9'h1F0, redirect target used on a misaligned target (only with MISALIGN_TRAP_EN).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- Stall  in  1  hazard-unit hold; PC does not advance.
- PcSel  in  1  redirect request from EX (branch taken / JAL / JALR).
- BrPC  in  32  redirect target byte address.
- PC  out  PC_W  current fetch address to instruction memory.
- PC_Valid  out  1  fetch slot at PC is a real instruction.
- Flush_IF_ID  out  1  clear IF/ID register at next edge.
- Flush_ID_EX  out  1  clear ID/EX register at next edge.
- Redirect_Count  out  32  number of accepted redirects.
- Misalign_Trap  out  1  one-cycle pulse, misaligned target seen (macro only).

Behaviour:
- Reset (reset=1 at an edge): PC=RESET_PC, PC_Valid=0, state=WARMUP, squash counter=0, Redirect_Count=0, Misalign_Trap=0. Flush outputs are 0 while reset=1.
- Reset has priority over everything, including a redirect in the same cycle. Reset mid-squash discards the squash window.
- States: WARMUP, RUN, SQUASH.
  - WARMUP -> RUN after exactly one cycle.
  - RUN -> SQUASH on an accepted redirect.
  - SQUASH -> RUN when the counter reaches SQUASH_CYCLES.
- PC_Valid: 0 in WARMUP, 1 in RUN and SQUASH.
- Accepted redirect: accept = PcSel && state==RUN. PcSel in WARMUP or SQUASH is ignored: no PC change, no flush, no count.
- On accept, in the same cycle (combinational): Flush_IF_ID=1 and Flush_ID_EX=1.
- On accept, at the next edge:
  - PC <= target.
  - Redirect_Count += 1 (wraps at 2^32).
  - Squash counter <= 1; state <= SQUASH.
- Target = BrPC[PC_W-1:0] with bits [1:0] forced to 0. Upper BrPC bits are silently truncated.
- Redirect beats Stall: if accept and Stall are both 1, the redirect is taken.
- No accept, Stall=1: PC holds.
- No accept, Stall=0, state != WARMUP: PC <= PC+4 modulo 2^PC_W. Wraps from max aligned value to 0.
- WARMUP: PC holds at RESET_PC.
- SQUASH: PC advances or holds per Stall exactly as in RUN. The squash counter increments every cycle, including stalled cycles. Exit to RUN on the edge where counter==SQUASH_CYCLES.
- Latency: redirect visible on PC one cycle after PcSel; flush same cycle.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: on accept with BrPC[1:0] != 0:
  - Target = TRAP_PC instead of the truncated BrPC.
  - Misalign_Trap pulses 1 for the cycle after acceptance (registered).
  - Flush, count and squash behave as for a normal redirect.
- Not defined: low two bits forced to 0 as above; Misalign_Trap tied to 0.

Test Plan:
- Reset release: reset=1 for 3 cycles, then 0 -> PC=0, PC_Valid=0 for 1 cycle. Then PC=0,4,8,C with PC_Valid=1.
- Taken branch: at PC=0x10, PcSel=1, BrPC=0x40 -> Flush_IF_ID=Flush_ID_EX=1 that cycle. Next PC=0x40, Redirect_Count=1.
- Squash window: PcSel=1 with BrPC=0x80, then PcSel=1 with BrPC=0xC0 in the next 2 cycles -> only the first is accepted. PC goes 0x80,0x84,0x88, count +1, no flush on the ignored cycles.
- Stall vs redirect: Stall=1 for 3 cycles holds PC=0x24. PcSel=1 with BrPC=0x100 during the stall -> PC=0x100 next cycle.
- Wrap and truncation: PC=0x1FC, Stall=0 -> PC=0x000. Separately, BrPC=0xFFFF_FE0B -> PC=0x008 (without macro).
- With MISALIGN_TRAP_EN: BrPC=0x42 -> PC=0x1F0, Misalign_Trap=1 for exactly one cycle. Reset asserted in that SQUASH window -> PC=0, state WARMUP.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch PC sequencer: owns the architectural PC, accepts EX redirects, flushes IF/ID and ID/EX, squashes follow-up redirects.
// Optional misaligned-target trap enabled by defining MISALIGN_TRAP_EN.
module fetch_pc_unit #(
    parameter int unsigned          PC_W          = 9,
    parameter logic [PC_W-1:0]      RESET_PC      = '0,
    parameter int unsigned          SQUASH_CYCLES = 2,
    parameter logic [PC_W-1:0]      TRAP_PC       = 9'h1F0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Stall,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    output logic [PC_W-1:0] PC,
    output logic            PC_Valid,
    output logic            Flush_IF_ID,
    output logic            Flush_ID_EX,
    output logic [31:0]     Redirect_Count,
    output logic            Misalign_Trap
);

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        RUN    = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [2:0]      squash_cnt, squash_cnt_next;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] target;
    logic            accept;
    logic            misaligned;
    logic            unused_brpc_bits;

    assign accept = PcSel && (state == RUN) && !reset;

    // Bits above PC_W are truncated by design; the low two only matter for the trap.
    assign unused_brpc_bits = ^{BrPC[31:PC_W], BrPC[1:0]};

`ifdef MISALIGN_TRAP_EN
    assign misaligned = (BrPC[1:0] != 2'b00);
    assign target     = misaligned ? TRAP_PC : {BrPC[PC_W-1:2], 2'b00};
`else
    assign misaligned = 1'b0;
    assign target     = {BrPC[PC_W-1:2], 2'b00};
`endif

    always_comb begin
        state_next      = state;
        squash_cnt_next = squash_cnt;
        pc_next         = PC;
        Flush_IF_ID     = 1'b0;
        Flush_ID_EX     = 1'b0;

        case (state)
            WARMUP: begin
                state_next = RUN;
            end
            RUN: begin
                if (accept) begin
                    state_next      = SQUASH;
                    squash_cnt_next = 3'd1;
                end
            end
            SQUASH: begin
                // Counter runs on stalled cycles too; exit once it reaches the window length.
                if (squash_cnt == 3'(SQUASH_CYCLES)) begin
                    state_next      = RUN;
                    squash_cnt_next = '0;
                end else begin
                    squash_cnt_next = squash_cnt + 3'd1;
                end
            end
            default: begin
                state_next = WARMUP;
            end
        endcase

        if (accept) begin
            Flush_IF_ID = 1'b1;
            Flush_ID_EX = 1'b1;
            pc_next     = target;
        end else if (!Stall && state != WARMUP) begin
            pc_next = PC + PC_W'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= WARMUP;
            squash_cnt     <= '0;
            PC             <= RESET_PC;
            Redirect_Count <= '0;
            Misalign_Trap  <= 1'b0;
        end else begin
            state          <= state_next;
            squash_cnt     <= squash_cnt_next;
            PC             <= pc_next;
            Redirect_Count <= accept ? Redirect_Count + 32'd1 : Redirect_Count;
            Misalign_Trap  <= accept && misaligned;
        end
    end

    assign PC_Valid = (state != WARMUP);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit (default parameters; trap expectations follow MISALIGN_TRAP_EN).
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic        PcSel;
    logic [31:0] BrPC;
    logic [8:0]  PC;
    logic        PC_Valid;
    logic        Flush_IF_ID;
    logic        Flush_ID_EX;
    logic [31:0] Redirect_Count;
    logic        Misalign_Trap;

    int unsigned errors = 0;
    int unsigned checks = 0;

    fetch_pc_unit #(
        .PC_W(9),
        .RESET_PC(9'h000),
        .SQUASH_CYCLES(2),
        .TRAP_PC(9'h1F0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Stall(Stall),
        .PcSel(PcSel),
        .BrPC(BrPC),
        .PC(PC),
        .PC_Valid(PC_Valid),
        .Flush_IF_ID(Flush_IF_ID),
        .Flush_ID_EX(Flush_ID_EX),
        .Redirect_Count(Redirect_Count),
        .Misalign_Trap(Misalign_Trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pc(input string tag, input logic [8:0] exp_pc, input logic exp_valid);
        check({tag, ".pc"}, 32'(PC), 32'(exp_pc));
        check({tag, ".valid"}, 32'(PC_Valid), 32'(exp_valid));
    endtask

    task automatic check_flush(input string tag, input logic exp);
        #1;
        check({tag, ".fl_ifid"}, 32'(Flush_IF_ID), 32'(exp));
        check({tag, ".fl_idex"}, 32'(Flush_ID_EX), 32'(exp));
    endtask

    initial begin
        logic [8:0] trunc_exp;
        logic [8:0] mis_exp;
        logic       trap_exp;
`ifdef MISALIGN_TRAP_EN
        trunc_exp = 9'h1F0;
        mis_exp   = 9'h1F0;
        trap_exp  = 1'b1;
`else
        trunc_exp = 9'h008;
        mis_exp   = 9'h040;
        trap_exp  = 1'b0;
`endif
        reset = 1'b1; Stall = 1'b0; PcSel = 1'b1; BrPC = 32'h40;
        repeat (3) step();
        check_pc("rst", 9'h000, 1'b0);
        check("rst.count", Redirect_Count, 32'd0);
        check("rst.trap", 32'(Misalign_Trap), 32'd0);
        check_flush("rst", 1'b0);

        // Release: WARMUP cycle ignores PcSel.
        reset = 1'b0;
        check_flush("warm", 1'b0);
        step();
        PcSel = 1'b0;
        check_pc("run0", 9'h000, 1'b1);
        check("warm.count", Redirect_Count, 32'd0);
        step(); check_pc("run4", 9'h004, 1'b1);
        step(); check_pc("run8", 9'h008, 1'b1);
        step(); check_pc("runC", 9'h00C, 1'b1);
        step(); check_pc("run10", 9'h010, 1'b1);

        // Taken branch.
        PcSel = 1'b1; BrPC = 32'h40;
        check_flush("br", 1'b1);
        step(); PcSel = 1'b0;
        check_pc("br", 9'h040, 1'b1);
        check("br.count", Redirect_Count, 32'd1);
        check_flush("br.after", 1'b0);
        step(); check_pc("sq44", 9'h044, 1'b1);
        step(); check_pc("sq48", 9'h048, 1'b1);

        // Squash window ignores follow-up redirects.
        PcSel = 1'b1; BrPC = 32'h80;
        check_flush("sq.acc", 1'b1);
        step(); BrPC = 32'hC0;
        check_pc("sq80", 9'h080, 1'b1);
        check_flush("sq.ign1", 1'b0);
        step();
        check_pc("sq84", 9'h084, 1'b1);
        check_flush("sq.ign2", 1'b0);
        step(); PcSel = 1'b0;
        check_pc("sq88", 9'h088, 1'b1);
        check("sq.count", Redirect_Count, 32'd2);
        step(); check_pc("sq8C", 9'h08C, 1'b1);

        // Stall holds; redirect beats stall.
        Stall = 1'b1;
        step(); check_pc("stall1", 9'h08C, 1'b1);
        step(); check_pc("stall2", 9'h08C, 1'b1);
        PcSel = 1'b1; BrPC = 32'h100;
        check_flush("stall.br", 1'b1);
        step(); PcSel = 1'b0; Stall = 1'b0;
        check_pc("stall.br", 9'h100, 1'b1);
        check("stall.count", Redirect_Count, 32'd3);
        step(); check_pc("s104", 9'h104, 1'b1);
        step(); check_pc("s108", 9'h108, 1'b1);

        // Truncation of upper and low target bits.
        PcSel = 1'b1; BrPC = 32'hFFFF_FE0B;
        check_flush("trunc", 1'b1);
        step(); PcSel = 1'b0;
        check_pc("trunc", trunc_exp, 1'b1);
        check("trunc.count", Redirect_Count, 32'd4);
        check("trunc.trap", 32'(Misalign_Trap), 32'(trap_exp));
        step();
        check("trunc.trap_end", 32'(Misalign_Trap), 32'd0);
        step();

        // Wrap from max aligned PC.
        PcSel = 1'b1; BrPC = 32'h1F8;
        step(); PcSel = 1'b0;
        check_pc("w1F8", 9'h1F8, 1'b1);
        check("wrap.count", Redirect_Count, 32'd5);
        step(); check_pc("w1FC", 9'h1FC, 1'b1);
        step(); check_pc("wrap", 9'h000, 1'b1);

        // Misaligned target, then reset inside the squash window.
        PcSel = 1'b1; BrPC = 32'h42;
        check_flush("mis", 1'b1);
        step(); PcSel = 1'b0;
        check_pc("mis", mis_exp, 1'b1);
        check("mis.trap", 32'(Misalign_Trap), 32'(trap_exp));
        check("mis.count", Redirect_Count, 32'd6);
        reset = 1'b1; PcSel = 1'b1;
        check_flush("mis.rst", 1'b0);
        step();
        check_pc("sqrst", 9'h000, 1'b0);
        check("sqrst.count", Redirect_Count, 32'd0);
        check("sqrst.trap", 32'(Misalign_Trap), 32'd0);
        reset = 1'b0; PcSel = 1'b0;
        step(); check_pc("sqrst.run", 9'h000, 1'b1);
        step(); check_pc("sqrst.run4", 9'h004, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
